// File: rtl/dac_spi_pkg.sv
// Shared constants and state type for the DAC SPI frame format.
package dac_spi_pkg;

  localparam int unsigned DAC_DATA_WIDTH = 24;
  localparam int unsigned DAC_CODE_WIDTH = 16;
  localparam int unsigned DAC_CMD_WIDTH  = 4;

  localparam logic [DAC_CMD_WIDTH-1:0] DAC_CMD_WRITE_UPDATE = 4'b0011;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    DONE
  } dac_rx_state_t;

endpackage

// File: rtl/sync_edge_det.sv
// Multi-flop synchronizer followed by an edge-detect register.
module sync_edge_det #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk_i,
  input  logic arst_i,
  input  logic d_i,
  output logic q_o,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;

  // Synchronizer chain plus previous-value register; reset low so a line
  // already low at reset release produces no falling edge.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
    end
  end

  assign q_o    = sync_q[STAGES-1];
  assign rise_o = q_o & ~prev_q;
  assign fall_o = ~q_o & prev_q;

endmodule

// File: rtl/dac_spi_rx.sv
// SPI receiver for 24-bit DAC write frames: command, code, pad, MSB first.
module dac_spi_rx
  import dac_spi_pkg::*;
#(
  parameter int unsigned           DATA_WIDTH       = DAC_DATA_WIDTH,
  parameter int unsigned           CODE_WIDTH       = DAC_CODE_WIDTH,
  parameter int unsigned           CMD_WIDTH        = DAC_CMD_WIDTH,
  parameter logic [CMD_WIDTH-1:0]  CMD_WRITE_UPDATE = DAC_CMD_WRITE_UPDATE,
  parameter int unsigned           SYNC_STAGES      = 2,
  parameter logic [CODE_WIDTH-1:0] CODE_RESET       = '0
) (
  input  logic                  clk_i,
  input  logic                  arst_i,
  input  logic                  sync_i,
  input  logic                  sclk_i,
  input  logic                  sdi_i,
  output logic [DATA_WIDTH-1:0] frame_o,
  output logic                  frame_vld_o,
  output logic [CODE_WIDTH-1:0] dac_code_o,
  output logic                  code_vld_o,
  output logic                  len_err_o,
  output logic                  cmd_err_o,
  output logic [15:0]           frame_cnt_o,
  output logic                  busy_o
);

  // Counter must hold DATA_WIDTH+1, the overrun marker.
  localparam int unsigned CntW = $clog2(DATA_WIDTH + 2);
  localparam logic [CntW-1:0] CntFull = CntW'(DATA_WIDTH);
  localparam logic [CntW-1:0] CntOvr  = CntW'(DATA_WIDTH + 1);

  logic sync_q, sync_rise, sync_fall;
  logic sclk_q, sclk_rise, sclk_fall;
  logic sdi_q, sdi_rise, sdi_fall;
  logic unused_edges;

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sync_det (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    (sync_i),
    .q_o    (sync_q),
    .rise_o (sync_rise),
    .fall_o (sync_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sclk_det (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    (sclk_i),
    .q_o    (sclk_q),
    .rise_o (sclk_rise),
    .fall_o (sclk_fall)
  );

  sync_edge_det #(.STAGES(SYNC_STAGES)) u_sdi_det (
    .clk_i  (clk_i),
    .arst_i (arst_i),
    .d_i    (sdi_i),
    .q_o    (sdi_q),
    .rise_o (sdi_rise),
    .fall_o (sdi_fall)
  );

  // Levels and rising sclk edges are not needed; sdi is used as a level only.
  assign unused_edges = sync_q ^ sclk_q ^ sclk_rise ^ sdi_rise ^ sdi_fall;

  dac_rx_state_t         state_q, state_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [CntW-1:0]       cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0] frame_q, frame_d;
  logic [CODE_WIDTH-1:0] code_q, code_d;
  logic [15:0]           fcnt_q, fcnt_d;
  logic                  frame_vld_q, frame_vld_d;
  logic                  code_vld_q, code_vld_d;
  logic                  len_err_q, len_err_d;
  logic                  cmd_err_q, cmd_err_d;

  // Next-state, frame assembly and DONE-time decode.
  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    cnt_d       = cnt_q;
    frame_d     = frame_q;
    code_d      = code_q;
    fcnt_d      = fcnt_q;
    frame_vld_d = 1'b0;
    code_vld_d  = 1'b0;
    len_err_d   = 1'b0;
    cmd_err_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (sync_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      SHIFT: begin
        // A bit arriving with the closing sync edge is still counted.
        if (sclk_fall) begin
          shift_d = {shift_q[DATA_WIDTH-2:0], sdi_q};
          if (cnt_q != CntOvr) cnt_d = cnt_q + 1'b1;
        end
        if (sync_rise) state_d = DONE;
      end

      DONE: begin
        if (cnt_q == CntFull) begin
          frame_d     = shift_q;
          frame_vld_d = 1'b1;
          if (shift_q[DATA_WIDTH-1 -: CMD_WIDTH] == CMD_WRITE_UPDATE) begin
            code_d     = shift_q[DATA_WIDTH-CMD_WIDTH-1 -: CODE_WIDTH];
            code_vld_d = 1'b1;
            if (fcnt_q != 16'hFFFF) fcnt_d = fcnt_q + 16'd1;
          end else begin
            cmd_err_d = 1'b1;
          end
        end else begin
          len_err_d = 1'b1;
        end
        state_d = IDLE;
        // A new frame may start immediately behind the previous one.
        if (sync_fall) begin
          shift_d = '0;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end

      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge clk_i or negedge arst_i) begin
    if (!arst_i) begin
      state_q     <= IDLE;
      shift_q     <= '0;
      cnt_q       <= '0;
      frame_q     <= '0;
      code_q      <= CODE_RESET;
      fcnt_q      <= '0;
      frame_vld_q <= 1'b0;
      code_vld_q  <= 1'b0;
      len_err_q   <= 1'b0;
      cmd_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      cnt_q       <= cnt_d;
      frame_q     <= frame_d;
      code_q      <= code_d;
      fcnt_q      <= fcnt_d;
      frame_vld_q <= frame_vld_d;
      code_vld_q  <= code_vld_d;
      len_err_q   <= len_err_d;
      cmd_err_q   <= cmd_err_d;
    end
  end

  assign frame_o     = frame_q;
  assign frame_vld_o = frame_vld_q;
  assign dac_code_o  = code_q;
  assign code_vld_o  = code_vld_q;
  assign len_err_o   = len_err_q;
  assign cmd_err_o   = cmd_err_q;
  assign frame_cnt_o = fcnt_q;
  assign busy_o      = (state_q == SHIFT);

endmodule
